// File: rtl/mc_control_fsm.sv
// Multi-cycle controller for the MIPS datapath: latches one instruction and sequences
// the datapath control lines through DECODE/EXEC/MEM/WB, with a bounded dmem wait.
module mc_control_fsm #(
    parameter logic [4:0] ALU_ADD     = 5'd0,
    parameter logic [4:0] ALU_SUB     = 5'd1,
    parameter logic [4:0] ALU_AND     = 5'd2,
    parameter logic [4:0] ALU_OR      = 5'd3,
    parameter logic [4:0] ALU_SLT     = 5'd4,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] instr_q,
    input  logic        iszero,
    input  logic        mem_ack,
    output logic [4:0]  alu_control,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUsrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        retired,
    output logic        branch_taken,
    output logic        illegal,
    output logic        mem_err
);

    localparam int             CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_ILL} cls_t;

    state_t        state_q, state_d;
    cls_t          cls_q, cls_d, dec_cls;
    logic [4:0]    alu_q, alu_d, dec_alu;
    logic [31:0]   instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ctrl_on;

    // Instruction class is resolved at accept time so later states only look at cls_q.
    always_comb begin
        dec_cls = C_ILL;
        dec_alu = ALU_ADD;
        case (instr[31:26])
            6'b000000: begin
                case (instr[5:0])
                    6'b100000: begin dec_cls = C_R; dec_alu = ALU_ADD; end
                    6'b100010: begin dec_cls = C_R; dec_alu = ALU_SUB; end
                    6'b100100: begin dec_cls = C_R; dec_alu = ALU_AND; end
                    6'b100101: begin dec_cls = C_R; dec_alu = ALU_OR;  end
                    6'b101010: begin dec_cls = C_R; dec_alu = ALU_SLT; end
                    default:   dec_cls = C_ILL;
                endcase
            end
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b001000: dec_cls = C_ADDI;
            6'b000100: begin dec_cls = C_BEQ; dec_alu = ALU_SUB; end
            default:   dec_cls = C_ILL;
        endcase
    end

    assign ctrl_on = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        alu_d        = alu_q;
        instr_d      = instr_q;
        cnt_d        = cnt_q;
        instr_ready  = 1'b0;
        alu_control  = 5'd0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUsrc       = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        MemToReg     = 1'b0;
        retired      = 1'b0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
        mem_err      = 1'b0;

        if (ctrl_on) begin
            alu_control = alu_q;
            ALUsrc      = (cls_q == C_ADDI) || (cls_q == C_LW) || (cls_q == C_SW);
            RegDst      = (cls_q == C_R);
            MemToReg    = (cls_q == C_LW);
        end

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    cls_d   = dec_cls;
                    alu_d   = dec_alu;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls_q == C_ILL) begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_q == C_BEQ) begin
                    branch_taken = iszero;
                    retired      = 1'b1;
                    state_d      = S_IDLE;
                end else if ((cls_q == C_LW) || (cls_q == C_SW)) begin
                    cnt_d   = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                MemRead  = (cls_q == C_LW);
                MemWrite = (cls_q == C_SW);
                // An ack arriving in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    if (cls_q == C_LW) begin
                        state_d = S_WB;
                    end else begin
                        retired = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_err = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                retired  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset silences every strobe in the same cycle, so an in-flight write never lands.
        if (rst) begin
            instr_ready  = 1'b0;
            alu_control  = 5'd0;
            RegDst       = 1'b0;
            RegWrite     = 1'b0;
            ALUsrc       = 1'b0;
            MemWrite     = 1'b0;
            MemRead      = 1'b0;
            MemToReg     = 1'b0;
            retired      = 1'b0;
            branch_taken = 1'b0;
            illegal      = 1'b0;
            mem_err      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cls_q   <= C_ILL;
            alu_q   <= 5'd0;
            instr_q <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle expectations come from an instruction-level schedule
// model; a single compare process checks every cycle, plus literal latency/count pins.
module tb_mc_control_fsm;

    localparam int TO = 4;
    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] instr_q;
    logic        iszero;
    logic        mem_ack;
    logic [4:0]  alu_control;
    logic        RegDst, RegWrite, ALUsrc, MemWrite, MemRead, MemToReg;
    logic        retired, branch_taken, illegal, mem_err;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .instr_q(instr_q), .iszero(iszero), .mem_ack(mem_ack),
        .alu_control(alu_control), .RegDst(RegDst), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg), .retired(retired),
        .branch_taken(branch_taken), .illegal(illegal), .mem_err(mem_err)
    );

    typedef struct packed {
        logic        ready;
        logic [4:0]  alu;
        logic        regdst, regwrite, alusrc, memwrite, memread, memtoreg;
        logic        ret, bt, ill, merr;
        logic [31:0] iq;
    } ov_t;

    typedef struct {
        ov_t   exp;
        string tag;
        int    idx;
    } chk_t;

    chk_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    logic [31:0] model_iq = 32'd0;

    int n_rw = 0, n_mw = 0, n_mr = 0, n_bt = 0, n_ill = 0, n_merr = 0;
    int last_ret = -1, last_ill = -1;

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            chk_t c;
            ov_t  got;
            c   = expq.pop_front();
            got = {instr_ready, alu_control, RegDst, RegWrite, ALUsrc, MemWrite, MemRead,
                   MemToReg, retired, branch_taken, illegal, mem_err, instr_q};
            checks++;
            if (got !== c.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", c.tag, c.idx, got, c.exp);
            end else begin
                $display("ok   %s cycle %0d: outputs %h", c.tag, c.idx, got);
            end
            if (RegWrite === 1'b1) n_rw++;
            if (MemWrite === 1'b1) n_mw++;
            if (MemRead  === 1'b1) n_mr++;
            if (branch_taken === 1'b1) n_bt++;
            if (illegal  === 1'b1) begin n_ill++; last_ill = c.idx; end
            if (mem_err  === 1'b1) n_merr++;
            if (retired  === 1'b1) last_ret = c.idx;
        end
    end

    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic z, input logic ack,
                        input logic r, input ov_t e, input string tag);
        chk_t c;
        instr_valid = v;
        instr       = ins;
        iszero      = z;
        mem_ack     = ack;
        rst         = r;
        c.exp = e; c.tag = tag; c.idx = cyc_n;
        expq.push_back(c);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        ov_t e;
        e = '0; e.ready = 1'b1; e.iq = model_iq;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e, tag);
    endtask

    function automatic void classify(input logic [31:0] ins, output int k, output logic [4:0] alu);
        k = K_ILL; alu = 5'd0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: k = K_R;
                6'h22: begin k = K_R; alu = 5'd1; end
                6'h24: begin k = K_R; alu = 5'd2; end
                6'h25: begin k = K_R; alu = 5'd3; end
                6'h2A: begin k = K_R; alu = 5'd4; end
                default: k = K_ILL;
            endcase
            6'h23: k = K_LW;
            6'h2B: k = K_SW;
            6'h08: k = K_ADDI;
            6'h04: begin k = K_BEQ; alu = 5'd1; end
            default: k = K_ILL;
        endcase
    endfunction

    // Schedule model: accept, decode, exec, optional MEM wait, optional WB.
    // ack_at is the MEM cycle (0-based) carrying mem_ack, -1 for none; noise drives
    // instr_valid/mem_ack while busy outside MEM; rst_wb asserts reset in the WB cycle.
    task automatic run(input logic [31:0] ins, input logic z, input int ack_at,
                       input logic noise, input logic rst_wb, input string tag, output int acc);
        int         k;
        logic [4:0] alu;
        ov_t        e, c;
        classify(ins, k, alu);
        e = '0; e.ready = 1'b1; e.iq = model_iq;
        acc = cyc_n;
        step(1'b1, ins, z, noise, 1'b0, e, {tag, ".accept"});
        model_iq = ins;

        e = '0; e.iq = model_iq; e.ill = (k == K_ILL);
        step(noise, ~ins, z, noise, 1'b0, e, {tag, ".decode"});
        if (k == K_ILL) return;

        c = '0; c.iq = model_iq; c.alu = alu;
        c.alusrc   = (k == K_ADDI) || (k == K_LW) || (k == K_SW);
        c.regdst   = (k == K_R);
        c.memtoreg = (k == K_LW);

        e = c;
        if (k == K_BEQ) begin e.ret = 1'b1; e.bt = z; end
        step(noise, ~ins, z, noise, 1'b0, e, {tag, ".exec"});
        if (k == K_BEQ) return;

        if (k == K_LW || k == K_SW) begin
            for (int m = 0; m < TO; m++) begin
                e = c;
                e.memread  = (k == K_LW);
                e.memwrite = (k == K_SW);
                if (m == ack_at) begin
                    e.ret = (k == K_SW);
                    step(noise, ~ins, z, 1'b1, 1'b0, e, {tag, ".mem_ack"});
                    break;
                end
                if (m == TO - 1) begin
                    e.merr = 1'b1;
                    step(noise, ~ins, z, 1'b0, 1'b0, e, {tag, ".mem_timeout"});
                    return;
                end
                step(noise, ~ins, z, 1'b0, 1'b0, e, {tag, ".mem_wait"});
            end
            if (k == K_SW) return;
        end

        if (rst_wb) begin
            e = '0; e.iq = model_iq;
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e, {tag, ".wb_reset"});
            model_iq = 32'd0;
            return;
        end
        e = c; e.regwrite = 1'b1; e.ret = 1'b1;
        step(noise, ~ins, z, noise, 1'b0, e, {tag, ".wb"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rw0, mw0, mr0, bt0, il0, me0;
        ov_t e;
        rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; iszero = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        e = '0;
        step(1'b1, 32'h00221820, 1'b0, 1'b1, 1'b1, e, "reset_hold");
        idle("after_reset");

        // add: pins WB/retire at accept+3 and a single RegWrite cycle
        rw0 = n_rw;
        run(32'h00221820, 1'b0, -1, 1'b0, 1'b0, "add", acc);
        lit("add_retire_latency", last_ret - acc, 3);
        lit("add_regwrite_cycles", n_rw - rw0, 1);
        idle("idle");

        run(32'h00221822, 1'b0, -1, 1'b1, 1'b0, "sub_noisy", acc);
        run(32'h00221824, 1'b0, -1, 1'b0, 1'b0, "and", acc);
        run(32'h00221825, 1'b0, -1, 1'b0, 1'b0, "or", acc);
        run(32'h0022182A, 1'b0, -1, 1'b0, 1'b0, "slt", acc);
        run(32'h20220005, 1'b0, -1, 1'b0, 1'b0, "addi", acc);

        // lw with ack on the third MEM cycle
        mr0 = n_mr; rw0 = n_rw;
        run(32'h8C220004, 1'b0, 2, 1'b0, 1'b0, "lw", acc);
        lit("lw_memread_cycles", n_mr - mr0, 3);
        lit("lw_retire_latency", last_ret - acc, 6);
        lit("lw_regwrite_cycles", n_rw - rw0, 1);

        // lw with ack exactly in the timeout cycle: ack wins
        me0 = n_merr;
        run(32'h8C220004, 1'b0, TO - 1, 1'b0, 1'b0, "lw_ack_last", acc);
        lit("lw_ack_last_no_err", n_merr - me0, 0);
        lit("lw_ack_last_latency", last_ret - acc, 7);

        // sw with no ack: exactly TO MemWrite cycles then mem_err
        mw0 = n_mw; me0 = n_merr; rw0 = n_rw;
        run(32'hAC220004, 1'b0, -1, 1'b1, 1'b0, "sw_timeout", acc);
        lit("sw_memwrite_cycles", n_mw - mw0, 4);
        lit("sw_mem_err_pulses", n_merr - me0, 1);
        lit("sw_no_regwrite", n_rw - rw0, 0);
        idle("idle");

        run(32'hAC220004, 1'b0, 0, 1'b0, 1'b0, "sw_ack0", acc);
        lit("sw_ack0_latency", last_ret - acc, 3);

        bt0 = n_bt;
        run(32'h10220003, 1'b1, -1, 1'b0, 1'b0, "beq_taken", acc);
        lit("beq_taken_latency", last_ret - acc, 2);
        lit("beq_taken_pulses", n_bt - bt0, 1);
        bt0 = n_bt;
        run(32'h10220003, 1'b0, -1, 1'b0, 1'b0, "beq_not_taken", acc);
        lit("beq_not_taken_pulses", n_bt - bt0, 0);

        il0 = n_ill; rw0 = n_rw; mw0 = n_mw; mr0 = n_mr;
        run(32'hFC000000, 1'b0, -1, 1'b1, 1'b0, "ill_opcode", acc);
        lit("ill_opcode_latency", last_ill - acc, 1);
        run(32'h0000003F, 1'b0, -1, 1'b0, 1'b0, "ill_funct", acc);
        lit("ill_pulses", n_ill - il0, 2);
        lit("ill_no_strobes", (n_rw - rw0) + (n_mw - mw0) + (n_mr - mr0), 0);
        idle("idle");

        // reset asserted during WB: no RegWrite, clean IDLE afterwards
        rw0 = n_rw;
        run(32'h00221820, 1'b0, -1, 1'b0, 1'b1, "add_reset_wb", acc);
        lit("reset_wb_no_regwrite", n_rw - rw0, 0);
        idle("post_reset");
        run(32'h20220005, 1'b0, -1, 1'b0, 1'b0, "addi_after_reset", acc);
        idle("idle");
        idle("idle");

        lit("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
